// File: rtl/sbox_pipe_array_pkg.sv
// AES S-box tables, parity tables and the mode type shared by the sbox_pipe_array block.
// INV_SBOX and the parity tables are derived from SBOX at elaboration time.
package aes_sbox_pkg;

   typedef enum logic {MODE_FWD = 1'b0, MODE_INV = 1'b1} mode_e;

   localparam int unsigned MAX_LANES  = 16;
   localparam int unsigned MAX_STAGES = 4;

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [0:255][7:0] invert_table(input logic [0:255][7:0] t);
      logic [0:255][7:0] r;
      r = '0;
      for (int i = 0; i < 256; i++) r[t[i]] = 8'(i);
      return r;
   endfunction

   function automatic logic [0:255] parity_table(input logic [0:255][7:0] t);
      logic [0:255] r;
      for (int i = 0; i < 256; i++) r[i] = ^t[i];
      return r;
   endfunction

   localparam logic [0:255][7:0] INV_SBOX     = invert_table(SBOX);
   localparam logic [0:255]      SBOX_PAR     = parity_table(SBOX);
   localparam logic [0:255]      INV_SBOX_PAR = parity_table(INV_SBOX);

endpackage

// File: rtl/sbox_pipe_array_if.sv
// Handshake/data bundle for sbox_pipe_array; master drives beats in, slave is the engine.
// out_parity_err exists only when SBOX_PARITY_EN is defined.
interface sbox_pipe_array_if #(
   parameter int unsigned LANES = 16,
   parameter int unsigned TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_mode;
   logic [8*LANES-1:0]   in_data;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [8*LANES-1:0]   out_data;
   logic [TAG_W-1:0]     out_tag;
   logic                 out_mode;
   logic                 busy;
`ifdef SBOX_PARITY_EN
   logic                 out_parity_err;
`endif

   modport master (
      output in_valid, in_mode, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_mode, busy
`ifdef SBOX_PARITY_EN
      , input out_parity_err
`endif
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_mode, busy
`ifdef SBOX_PARITY_EN
      , output out_parity_err
`endif
   );
endinterface

// File: rtl/sbox_pipe_array_lane.sv
// Single-byte combinational AES S-box / inverse S-box lookup selected by mode.
module sbox_lane
   import aes_sbox_pkg::*;
(
   input  logic [7:0] i_byte,
   input  mode_e      i_mode,
   output logic [7:0] o_byte
);
   always_comb begin
      o_byte = SBOX[i_byte];
      if (i_mode == MODE_INV) o_byte = INV_SBOX[i_byte];
   end
endmodule

// File: rtl/sbox_pipe_array.sv
// Multi-lane pipelined AES SubBytes/InvSubBytes engine with valid/ready back-pressure.
// Define SBOX_PARITY_EN to carry per-lane parity and flag register faults on out_parity_err.
module sbox_pipe_array
   import aes_sbox_pkg::*;
#(
   parameter int unsigned LANES  = 16,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
) (
   input logic              clk,
   input logic              rst,
   sbox_pipe_array_if.slave bus
);
   localparam int unsigned W    = 8 * LANES;
   localparam int unsigned LAST = STAGES - 1;

   if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
      $error("sbox_pipe_array: LANES out of range 1..16");
   end
   if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("sbox_pipe_array: STAGES out of range 1..4");
   end

   logic [STAGES-1:0]            r_vld, r_mode, w_adv, w_nxt_vld, w_nxt_mode;
   logic [STAGES-1:0][TAG_W-1:0] r_tag, w_nxt_tag;
   logic [STAGES-1:0][W-1:0]     r_data, w_nxt_data;
   logic [W-1:0]                 w_lu_src, w_lu_out;
   logic                         w_lu_mode;

   // The lookup sits between stage 0 and stage 1, or in front of the only register.
   if (STAGES == 1) begin : g_lu_in
      assign w_lu_src  = bus.in_data;
      assign w_lu_mode = bus.in_mode;
   end else begin : g_lu_reg
      assign w_lu_src  = r_data[0];
      assign w_lu_mode = r_mode[0];
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sbox_lane u_lane (
         .i_byte (w_lu_src[8*i +: 8]),
         .i_mode (mode_e'(w_lu_mode)),
         .o_byte (w_lu_out[8*i +: 8])
      );
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign w_nxt_vld[k]  = bus.in_valid;
         assign w_nxt_mode[k] = bus.in_mode;
         assign w_nxt_tag[k]  = bus.in_tag;
         assign w_nxt_data[k] = (STAGES == 1) ? w_lu_out : bus.in_data;
      end else begin : g_body
         assign w_nxt_vld[k]  = r_vld[k-1];
         assign w_nxt_mode[k] = r_mode[k-1];
         assign w_nxt_tag[k]  = r_tag[k-1];
         assign w_nxt_data[k] = (k == 1) ? w_lu_out : r_data[k-1];
      end
   end

   // Stage k moves when downstream accepts or any stage at or after k is empty.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         logic a;
         a = bus.out_ready;
         for (int j = k; j < STAGES; j++) a = a | ~r_vld[j];
         w_adv[k] = a;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld  <= '0;
         r_mode <= '0;
         r_tag  <= '0;
         r_data <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_adv[k]) begin
               r_vld[k]  <= w_nxt_vld[k];
               r_mode[k] <= w_nxt_mode[k];
               r_tag[k]  <= w_nxt_tag[k];
               r_data[k] <= w_nxt_data[k];
            end
         end
      end
   end

   assign bus.in_ready  = w_adv[0];
   assign bus.out_valid = r_vld[LAST];
   assign bus.out_data  = r_data[LAST];
   assign bus.out_tag   = r_tag[LAST];
   assign bus.out_mode  = r_mode[LAST];
   assign bus.busy      = |r_vld;

`ifdef SBOX_PARITY_EN
   logic [STAGES-1:0][LANES-1:0] r_par, w_nxt_par;
   logic [LANES-1:0]             w_in_par, w_out_par;

   // Parity of the substituted byte is fetched at entry so every register is covered.
   for (genvar i = 0; i < LANES; i++) begin : g_par
      assign w_in_par[i]  = bus.in_mode ? INV_SBOX_PAR[bus.in_data[8*i +: 8]]
                                        : SBOX_PAR[bus.in_data[8*i +: 8]];
      assign w_out_par[i] = ^r_data[LAST][8*i +: 8];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_par_stage
      if (k == 0) begin : g_head
         assign w_nxt_par[k] = w_in_par;
      end else begin : g_body
         assign w_nxt_par[k] = r_par[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_adv[k]) r_par[k] <= w_nxt_par[k];
         end
      end
   end

   assign bus.out_parity_err = r_vld[LAST] & (|(w_out_par ^ r_par[LAST]));
`endif

endmodule

// File: tb/tb_sbox_pipe_array.sv
// Scoreboard bench for sbox_pipe_array; reference S-boxes are built from GF(2^8) arithmetic.
module tb_sbox_pipe_array;
   localparam int unsigned LANES  = 16;
   localparam int unsigned STAGES = 2;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned W      = 8 * LANES;

   typedef struct {
      logic [W-1:0]     data;
      logic [TAG_W-1:0] tag;
      logic             mode;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   logic rdy_rand = 1'b0;
   logic rdy_force = 1'b1;
   exp_t exp_q[$];
   logic [7:0] fwd_tbl[256];
   logic [7:0] inv_tbl[256];

   sbox_pipe_array_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

   sbox_pipe_array #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      #2;
      bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox_math(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(a, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic m);
      logic [W-1:0] r;
      for (int i = 0; i < LANES; i++) r[8*i +: 8] = m ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
      return r;
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Present one beat at posedge+1, hold until accepted, then release in_valid.
   task automatic send(input logic [W-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                       input logic [W-1:0] e);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      bus.in_tag   = t;
      while (1) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back('{data: e, tag: t, mode: m});
            break;
         end
         n++;
         if (n > 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [W-1:0] d, input logic m, input logic [TAG_W-1:0] t);
      send(d, m, t, model(d, m));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_queue_empty", W'(exp_q.size()), '0);
   endtask

   // Monitor: pops on every output transfer and checks hold-stability under stall.
   initial begin
      logic             prev_v;
      logic [W-1:0]     prev_d;
      logic [TAG_W-1:0] prev_t;
      logic             prev_m;
      exp_t             e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
            continue;
         end
         if (prev_v) begin
            check("stall_valid", W'(bus.out_valid), W'(1));
            check("stall_data", bus.out_data, prev_d);
            check("stall_tag_mode", W'({bus.out_tag, bus.out_mode}), W'({prev_t, prev_m}));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_beat: got tag %h expected no beat", bus.out_tag);
            end else begin
               e = exp_q.pop_front();
               check("out_data", bus.out_data, e.data);
               check("out_tag", W'(bus.out_tag), W'(e.tag));
               check("out_mode", W'(bus.out_mode), W'(e.mode));
`ifdef SBOX_PARITY_EN
               check("parity_clean", W'(bus.out_parity_err), W'(0));
`endif
            end
         end
         prev_v = bus.out_valid && !bus.out_ready;
         prev_d = bus.out_data;
         prev_t = bus.out_tag;
         prev_m = bus.out_mode;
      end
   end

   initial begin
      logic [W-1:0] d, e, f;
      logic [TAG_W-1:0] tg;
      int n;

      for (int a = 0; a < 256; a++) begin
         fwd_tbl[a] = sbox_math(8'(a));
         inv_tbl[fwd_tbl[a]] = 8'(a);
      end

      bus.in_valid = 1'b0;
      bus.in_mode  = 1'b0;
      bus.in_data  = '0;
      bus.in_tag   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", W'(bus.out_valid), W'(0));
      check("rst_busy", W'(bus.busy), W'(0));
      check("rst_out_data", bus.out_data, '0);
      check("rst_out_tag_mode", W'({bus.out_tag, bus.out_mode}), W'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_in_ready", W'(bus.in_ready), W'(1));

      // Directed forward and inverse beats with hand-computed expectations.
      d = {LANES{8'h01}};
      d[7:0] = 8'h00;
      d[15:8] = 8'h53;
      e = {LANES{8'h7c}};
      e[7:0] = 8'h63;
      e[15:8] = 8'hed;
      send(d, 1'b0, 4'h5, e);
      d = {LANES{8'h00}};
      d[7:0] = 8'h63;
      d[23:16] = 8'hed;
      e = {LANES{8'h52}};
      e[7:0] = 8'h00;
      e[23:16] = 8'h53;
      send(d, 1'b1, 4'h6, e);
      drain();

      // Round trip over all 256 byte values with alternating mode.
      tg = '0;
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'(b * 16 + i);
         f = model(d, 1'b0);
         send(d, 1'b0, tg, f);
         tg++;
         send(f, 1'b1, tg, d);
         tg++;
      end
      drain();

      // Back-pressure: stall 5 cycles after the first output of an 8-beat stream.
      fork
         begin
            for (int b = 0; b < 8; b++) begin
               for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
               send_model(d, 1'(b % 2), 4'(b));
            end
         end
         begin
            n = 0;
            while (!bus.out_valid && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            rdy_force = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("bp_in_ready_low", W'(bus.in_ready), W'(0));
            check("bp_busy", W'(bus.busy), W'(1));
            repeat (2) @(posedge clk);
            #1;
            rdy_force = 1'b1;
         end
      join
      drain();

      // Reset with two beats in flight.
      rdy_force = 1'b0;
      send_model({LANES{8'h11}}, 1'b0, 4'h1);
      send_model({LANES{8'h22}}, 1'b1, 4'h2);
      check("pre_rst_busy", W'(bus.busy), W'(1));
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", W'(bus.out_valid), W'(0));
      check("mid_rst_busy", W'(bus.busy), W'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_force = 1'b1;
      @(posedge clk);
      #1;
      send_model({LANES{8'h3c}}, 1'b0, 4'h9);
      for (int i = 1; i < STAGES; i++) begin
         check("latency_early", W'(bus.out_valid), W'(0));
         @(posedge clk);
         #1;
      end
      check("latency_exact", W'(bus.out_valid), W'(1));
      drain();

`ifdef SBOX_PARITY_EN
      rdy_force = 1'b0;
      send_model({LANES{8'h5a}}, 1'b0, 4'h3);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("parity_before_flip", W'(bus.out_parity_err), W'(0));
      dut.r_data[STAGES-1][5*8+3] = ~dut.r_data[STAGES-1][5*8+3];
      #1;
      check("parity_after_flip", W'(bus.out_parity_err), W'(1));
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_force = 1'b1;
      @(posedge clk);
      #1;
`endif

      // Randomized traffic with random gaps and random back-pressure.
      rdy_rand = 1'b1;
      for (int b = 0; b < 200; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
         send_model(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      drain();
      rdy_rand = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("final_busy", W'(bus.busy), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/sbox_pipe_array.md
Name: sbox_pipe_array

Overview:
- Multi-lane, pipelined AES byte-substitution engine.
- Each lane applies either the forward S-box or the inverse S-box, selected per beat by a mode bit.
- Sits between the state register and ShiftRows / InvShiftRows. One instance serves both the encryption and decryption datapaths.
- Uses a valid/ready handshake with full-throughput back-pressure.

Parameters:
- LANES, 16: bytes substituted per beat (1..16). The default covers a full 128-bit AES state.
- STAGES, 2: pipeline register stages from input to output (1..4). Latency is STAGES cycles.
- TAG_W, 4: width of the user tag carried alongside each beat.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block accepts the beat this cycle.
- in_mode, input, 1: 0 = forward S-box, 1 = inverse S-box. Sampled with the beat.
- in_data, input, 8*LANES: lane i occupies bits [8i+7:8i].
- in_tag, input, TAG_W: opaque tag, returned unchanged with the beat.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts the beat.
- out_data, output, 8*LANES: substituted bytes, lane-aligned with in_data.
- out_tag, output, TAG_W: tag of the beat.
- out_mode, output, 1: mode of the beat.
- busy, output, 1: at least one stage holds a valid beat.

Behaviour:
- Reset: every stage valid bit, out_valid and busy go to 0. out_data, out_tag and out_mode go to 0.
  - in_ready is 1 while reset is deasserted and the pipe is empty.
  - Asserting rst mid-operation discards all in-flight beats immediately. No partial beat is emitted afterwards.
- Transfer rules:
  - Input transfer happens when in_valid and in_ready are both 1.
  - Output transfer happens when out_valid and out_ready are both 1.
- Substitution:
  - Lookup is purely per byte: out byte i = SBOX[in byte i] if mode = 0, else INV_SBOX[in byte i].
  - Lanes are independent. All 256 input values are defined; there is no X output.
  - The lookup is performed between stage 1 and stage 2. With STAGES = 1 it is performed before the single register.
- Pipeline:
  - A chain of STAGES registers. Each holds valid, mode, tag and a LANES-byte payload.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready is 1.
  - in_ready = ~valid[0] | advance[0]. This is combinational from out_ready through the chain, so there are no bubbles.
  - Latency: a beat accepted in cycle t appears on out_valid in cycle t+STAGES, provided there was no stall.
  - Throughput: one beat per cycle while out_ready is held high.
- Stall and ordering:
  - When out_ready is 0, out_data, out_tag and out_mode stay stable until the transfer.
  - Beats are never dropped, duplicated or reordered.
  - Once the pipe is full, in_ready = 0.
- Mode:
  - Mode may change on every beat. Mixed-mode beats coexist in the pipe, and each is processed with its own mode.
- busy = OR of all stage valid bits.
- Out-of-range parameters: if LANES or STAGES is out of range, elaboration fails via $error.

Optional Feature:
- Macro SBOX_PARITY_EN.
- When defined:
  - Adds output out_parity_err (1 bit).
  - Each stage also carries the expected per-lane parity of the substituted byte, taken from a parity table in the package.
  - At the last stage, out_parity_err = out_valid & (any lane's recomputed XOR parity of out_data != the carried parity bit).
  - out_parity_err resets to 0.
  - Purpose: detecting fault injection into the pipeline registers.
- When not defined: the port is absent and there is no extra logic.

Decomposition:
- Package aes_sbox_pkg holds:
  - the 256-entry SBOX and INV_SBOX constant arrays (8-bit);
  - the SBOX_PAR / INV_SBOX_PAR parity constants;
  - the mode typedef (MODE_FWD = 0, MODE_INV = 1).
- Sub-module sbox_lane: a combinational 8-bit lookup with a mode select, instantiated LANES times via generate.
- Pipeline control stays in the top module.

Test Plan:
- Forward single beat, LANES = 16, STAGES = 2: in_data lane0 = 0x00, lane1 = 0x53, rest 0x01, mode = 0, tag = 0x5.
  → Two cycles later, out lane0 = 0x63, lane1 = 0xED, rest 0x7C, out_tag = 0x5.
- Inverse beat: lane0 = 0x63, lane1 = 0x00, lane2 = 0xED, mode = 1.
  → lane0 = 0x00, lane1 = 0x52, lane2 = 0x53.
- Round-trip sweep: drive all 256 byte values through a forward pass, then feed the results back as inverse beats.
  → The original values return exactly. Mode alternates every beat, and tags match order.
- Back-pressure: stream 8 beats, hold out_ready = 0 for 5 cycles after the first output.
  → in_ready drops once STAGES beats are held. Output stays stable. All 8 beats emerge in order, with no loss or duplicates.
- Reset mid-stream: assert rst while 2 beats are in flight.
  → out_valid = 0 and busy = 0 immediately. After release, the next beat has latency exactly STAGES and no stale data appears.
- With SBOX_PARITY_EN: force-flip bit 3 of lane 5 in the last stage register.
  → out_parity_err = 1 for that beat only. Clean beats give 0.
